// File: rtl/nes_oam_dma.sv
// rtl/nes_oam_dma.sv - NES sprite OAM DMA controller with CPU bus pass-through
//
// Purpose:
//   Watches for a CPU write to DMA_REG_ADDR, stalls the CPU through RDY,
//   takes the bus and copies XFER_LEN bytes from page {written byte, 00}
//   to OAM_DATA_ADDR as alternating read/write cycles, then hands the bus
//   back. Outside READ/WRITE the bus outputs mirror the CPU combinationally.
//
// Ports:
//   phi2      in   CPU clock, all state on rising edge
//   b_rst     in   synchronous reset, active-low
//   cpu_addr  in   [15:0] CPU address
//   cpu_rw    in   CPU direction (1 = read, 0 = write)
//   cpu_dout  in   [7:0] CPU write data
//   cpu_rdy   out  RDY to the CPU, 0 stalls it
//   bus_addr  out  [15:0] muxed external bus address
//   bus_rw    out  muxed external bus direction
//   bus_dout  out  [7:0] muxed external bus write data
//   bus_din   in   [7:0] external bus read data
//   dma_busy  out  high whenever the controller is not idle

module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        phi2,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;
  logic       cpu_rdy_q, cpu_rdy_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    // parity 0 = get (read) cycle, 1 = put (write) cycle
    parity_d = ~parity_q;
    bus_addr = cpu_addr;
    bus_rw   = cpu_rw;
    bus_dout = cpu_dout;

    case (state_q)
      S_IDLE: begin
        // The trigger write itself still reaches the bus via the default mux.
        if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // The 6502 only honours RDY on read cycles, so wait out its writes.
        if (cpu_rw) begin
          state_d = parity_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        bus_addr = {page_q, idx_q};
        bus_rw   = 1'b1;
        data_d   = bus_din;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_rw   = 1'b0;
        bus_dout = data_q;
        // idx wraps on the last byte; its value after completion is unused.
        idx_d    = idx_q + 8'd1;
        state_d  = (idx_q == LAST_IDX) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cpu_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge phi2) begin
    if (!b_rst) begin
      state_q   <= S_IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      cpu_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      cpu_rdy_q <= cpu_rdy_d;
    end
  end

  assign cpu_rdy  = cpu_rdy_q;
  assign dma_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_nes_oam_dma.sv
// tb/tb_nes_oam_dma.sv - directed self-checking bench for nes_oam_dma

module tb_nes_oam_dma;

  logic        phi2;
  logic        b_rst;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        dma_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state
  bit          mon_on   = 1'b0;
  bit          mem_mode = 1'b0;
  bit          tb_par   = 1'b0;
  int          cyc      = 0;
  int          rd_cnt, wr_cnt, stall_cnt;
  int          rd_err, wr_err, busy_err, pass_err;
  int          first_rd, trig_cyc;
  logic [7:0]  exp_page;
  logic [15:0] last_rd_addr;
  logic [7:0]  last_wr_data;

  nes_oam_dma dut (
    .phi2     (phi2),
    .b_rst    (b_rst),
    .cpu_addr (cpu_addr),
    .cpu_rw   (cpu_rw),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .bus_addr (bus_addr),
    .bus_rw   (bus_rw),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .dma_busy (dma_busy)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input bit m);
    if (m) return ~a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bus_din = mem_byte(bus_addr, mem_mode);

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  // Expected get/put parity: 0 in the first cycle after reset, toggling after.
  always @(posedge phi2) tb_par <= b_rst ? ~tb_par : 1'b0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; stall_cnt = 0;
    rd_err = 0; wr_err = 0; busy_err = 0; pass_err = 0;
    first_rd = 0;
  endtask

  task automatic cpu_idle();
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_dout = 8'h00;
  endtask

  // Classify each cycle mid-period: a DMA cycle is one where the bus differs
  // from what the CPU is driving (the stalled CPU sits on a read of $8000).
  always @(negedge phi2) begin
    cyc++;
    if (mon_on) begin
      if (!cpu_rdy) stall_cnt++;
      if (dma_busy == cpu_rdy) busy_err++;
      if (bus_addr != cpu_addr || bus_rw != cpu_rw) begin
        if (!bus_rw) begin
          if (bus_addr != 16'h2004) wr_err++;
          if (bus_dout != mem_byte({exp_page, wr_cnt[7:0]}, mem_mode)) wr_err++;
          if (tb_par != 1'b1) wr_err++;
          if (rd_cnt != wr_cnt + 1) wr_err++;
          if (cpu_rdy) wr_err++;
          last_wr_data = bus_dout;
          wr_cnt++;
        end else begin
          if (bus_addr != {exp_page, rd_cnt[7:0]}) rd_err++;
          if (tb_par != 1'b0) rd_err++;
          if (rd_cnt != wr_cnt) rd_err++;
          if (cpu_rdy) rd_err++;
          if (rd_cnt == 0) first_rd = cyc;
          last_rd_addr = bus_addr;
          rd_cnt++;
        end
      end else if (bus_dout != cpu_dout) begin
        pass_err++;
      end
    end
  end

  // Trigger a transfer in a cycle of parity trig_par, optionally keep the CPU
  // writing for extra_wr HALT cycles, then run to completion and score it.
  task automatic run_xfer(input string tag, input logic [7:0] page, input bit trig_par,
                          input int extra_wr, input int exp_stall, input int exp_first);
    int n;
    clear_mon();
    exp_page = page;
    tick();
    cpu_idle();
    for (int i = 0; i < 3 && tb_par != trig_par; i++) tick();
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = page;
    trig_cyc = cyc + 1;
    mon_on   = 1'b1;
    for (int i = 0; i < extra_wr; i++) begin
      tick();
      cpu_addr = 16'h0400 + 16'(i); cpu_rw = 1'b0; cpu_dout = 8'hEE;
    end
    tick();
    cpu_idle();
    n = 0;
    while (dma_busy && n < 700) begin
      tick();
      n++;
    end
    @(negedge phi2);
    #1;
    mon_on = 1'b0;
    check_eq({tag, "_done"},   int'(dma_busy), 0);
    check_eq({tag, "_rdy"},    int'(cpu_rdy), 1);
    check_eq({tag, "_reads"},  rd_cnt, 256);
    check_eq({tag, "_writes"}, wr_cnt, 256);
    check_eq({tag, "_stall"},  stall_cnt, exp_stall);
    check_eq({tag, "_first"},  first_rd - trig_cyc, exp_first);
    check_eq({tag, "_rd_err"}, rd_err, 0);
    check_eq({tag, "_wr_err"}, wr_err, 0);
    check_eq({tag, "_busy"},   busy_err, 0);
    check_eq({tag, "_pass"},   pass_err, 0);
  endtask

  initial begin
    int n;
    clear_mon();
    exp_page = 8'h00;
    last_rd_addr = 16'h0000;
    last_wr_data = 8'hFF;
    b_rst = 1'b0;
    cpu_addr = 16'hABCD; cpu_rw = 1'b0; cpu_dout = 8'h3C;

    // reset state and pass-through while held in reset
    repeat (3) tick();
    @(negedge phi2);
    check_eq("rst_rdy",  int'(cpu_rdy), 1);
    check_eq("rst_busy", int'(dma_busy), 0);
    check_eq("rst_addr", int'(bus_addr), 'hABCD);
    check_eq("rst_rw",   int'(bus_rw), 0);
    check_eq("rst_dout", int'(bus_dout), 'h3C);
    tick();
    b_rst = 1'b1;
    cpu_idle();

    // idle pass-through: write $4013, read $4015, read of $4014
    tick();
    clear_mon();
    mon_on = 1'b1;
    cpu_addr = 16'h4013; cpu_rw = 1'b0; cpu_dout = 8'h55;
    @(negedge phi2);
    check_eq("idle_wr_addr", int'(bus_addr), 'h4013);
    check_eq("idle_wr_rw",   int'(bus_rw), 0);
    check_eq("idle_wr_dout", int'(bus_dout), 'h55);
    check_eq("idle_wr_rdy",  int'(cpu_rdy), 1);
    tick();
    cpu_addr = 16'h4015; cpu_rw = 1'b1; cpu_dout = 8'h00;
    @(negedge phi2);
    check_eq("idle_rd_addr", int'(bus_addr), 'h4015);
    check_eq("idle_rd_rw",   int'(bus_rw), 1);
    tick();
    cpu_addr = 16'h4014; cpu_rw = 1'b1;
    tick();
    cpu_idle();
    repeat (4) tick();
    mon_on = 1'b0;
    check_eq("idle_stall", stall_cnt, 0);
    check_eq("idle_dma",   rd_cnt + wr_cnt, 0);
    check_eq("idle_busy",  busy_err, 0);
    check_eq("idle_pass",  pass_err, 0);

    // HALT on put parity, HALT on get parity, CPU writes during HALT
    run_xfer("t1", 8'h02, 1'b0, 0, 513, 2);
    run_xfer("t2", 8'h05, 1'b1, 0, 514, 3);
    run_xfer("t3", 8'h06, 1'b0, 2, 515, 4);

    // top page, inverted-address data
    mem_mode = 1'b1;
    run_xfer("t4", 8'hFF, 1'b0, 0, 513, 2);
    check_eq("t4_last_data", int'(last_wr_data), 'h00);
    check_eq("t4_last_addr", int'(last_rd_addr), 'hFFFF);
    mem_mode = 1'b0;

    // reset during DMA write #100
    clear_mon();
    exp_page = 8'h07;
    tick();
    cpu_idle();
    for (int i = 0; i < 3 && tb_par != 1'b0; i++) tick();
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h07;
    mon_on = 1'b1;
    tick();
    cpu_idle();
    n = 0;
    while (!(rd_cnt == 100 && wr_cnt == 99) && n < 400) begin
      tick();
      n++;
    end
    b_rst = 1'b0;
    cpu_addr = 16'h1234; cpu_rw = 1'b1;
    tick();
    b_rst = 1'b1;
    @(negedge phi2);
    check_eq("t5_rdy",  int'(cpu_rdy), 1);
    check_eq("t5_busy", int'(dma_busy), 0);
    check_eq("t5_addr", int'(bus_addr), 'h1234);
    check_eq("t5_rw",   int'(bus_rw), 1);
    #1;
    check_eq("t5_wr100", wr_cnt, 100);
    check_eq("t5_err",   rd_err + wr_err, 0);
    clear_mon();
    repeat (10) tick();
    mon_on = 1'b0;
    check_eq("t5_quiet", rd_cnt + wr_cnt + stall_cnt, 0);
    run_xfer("t5b", 8'h03, 1'b0, 0, 513, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_oam_dma.md
Name: nes_oam_dma

Overview:
- Sprite OAM DMA controller sitting between the CPU core and the external NES bus.
- Detects a CPU write to $4014 and stalls the CPU through RDY.
- Takes ownership of the bus and copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port at $2004, one read/write pair per two phi2 cycles.
- Returns the bus to the CPU when done. When idle it is a transparent pass-through for CPU bus signals.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer; the written byte is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- phi2 in 1: CPU clock; all logic on rising edge.
- b_rst in 1: synchronous reset, active-low.
- cpu_addr in 16: CPU address bus.
- cpu_rw in 1: CPU direction, 1 = read, 0 = write.
- cpu_dout in 8: CPU write data.
- cpu_rdy out 1: RDY to the CPU; 0 stalls it.
- bus_addr out 16: muxed address to the external bus.
- bus_rw out 1: muxed direction to the external bus.
- bus_dout out 8: muxed write data to the external bus.
- bus_din in 8: read data from the external bus.
- dma_busy out 1: high whenever the state is not IDLE.

Behaviour:
- Single clock (phi2). b_rst is synchronous and active-low.
- Reset values:
  - state = IDLE; cpu_rdy = 1; dma_busy = 0.
  - page = 0; idx = 0; data latch = 0; parity = 0.
  - bus_* outputs pass through CPU signals.
- Parity: a 1-bit cycle-parity register toggles every phi2 cycle starting from 0 after reset. parity = 0 is a get (read) cycle; parity = 1 is a put (write) cycle.
- Trigger: in IDLE, if cpu_rw = 0 and cpu_addr = DMA_REG_ADDR:
  - latch page <= cpu_dout and idx <= 0;
  - go to HALT next cycle.
  - The trigger write itself still passes to the bus unchanged.
- HALT:
  - cpu_rdy = 0; the bus is still CPU-driven.
  - Remain in HALT while cpu_rw = 0, because the 6502 ignores RDY on write cycles.
  - When cpu_rw = 1: if parity = 1 (put), go to READ; if parity = 0 (get), go to ALIGN.
- ALIGN:
  - One dummy cycle; cpu_rdy = 0; the bus is CPU-driven, which is benign because the CPU is stalled on a read.
  - Go to READ. READ always lands on parity = 0.
- READ:
  - bus_addr = {page, idx}; bus_rw = 1.
  - Capture bus_din into the data latch at the end of the cycle.
  - Go to WRITE.
- WRITE:
  - bus_addr = OAM_DATA_ADDR; bus_rw = 0; bus_dout = data latch.
  - If idx = XFER_LEN-1, go to IDLE; otherwise idx++ and go to READ.
  - idx is 8 bits and wraps 255 -> 0 on completion; the final value is don't-care.
- Bus mux:
  - In READ or WRITE the DMA drives bus_addr, bus_rw and bus_dout.
  - In all other states they equal cpu_addr, cpu_rw and cpu_dout combinationally.
- cpu_rdy is registered from the state:
  - 0 in HALT, ALIGN, READ and WRITE.
  - It returns to 1 in the first IDLE cycle after the final WRITE.
- Latency:
  - Stall = 1 HALT cycle (plus any extra HALT cycles spent waiting out CPU writes) + 0 or 1 ALIGN cycle + 2*XFER_LEN.
  - With XFER_LEN = 256 the minimum stall is 513 or 514 cycles.
- Writes to DMA_REG_ADDR while dma_busy = 1 are ignored; the CPU is stalled, so this only occurs with a misbehaving bench.
- A reset asserted mid-transfer aborts on that edge. The next cycle is IDLE with cpu_rdy = 1 and no further DMA bus cycles.
- No OAM writes occur outside the WRITE state.

Test Plan:
1. Reset, then write $02 to $4014 in a cycle where HALT lands on parity = 1 -> HALT, then READ $0200 on the next cycle. Expect 256 alternating reads $0200..$02FF and writes to $2004 carrying the memory-model data, cpu_rdy low for exactly 513 cycles, and dma_busy falling with cpu_rdy rising.
2. Same as 1, but HALT lands on parity = 0 -> exactly one ALIGN cycle; cpu_rdy low for 514 cycles; every READ on parity 0 and every WRITE on parity 1.
3. CPU holds cpu_rw = 0 for 2 cycles after the trigger (simulated back-to-back writes) -> HALT lasts 3 cycles and no DMA bus cycle occurs until cpu_rw = 1; stall is 515 or 516 cycles.
4. Page $FF with memory pattern data = ~addr[7:0] -> the 256th write to $2004 carries $00, and the final read address is $FFFF with no wrap into page $00.
5. Assert b_rst at DMA write #100 -> the next cycle shows cpu_rdy = 1, dma_busy = 0 and the bus following the CPU; a fresh $4014 write then performs a complete 256-byte transfer.
6. While idle, CPU writes $55 to $4013 and reads $4015 -> the bus mirrors the CPU exactly, cpu_rdy stays 1 and no transfer starts.
